hood_mode_controller: RTL and testbench

Top-level mode sequencer for the exhaust hood. It converts single-cycle key pulses into the `current_mode` state and enforces the time limits of each mode: idle auto-off in STAND, a 60 s boost cap in LEVEL3, and a fixed self-clean duration. It drives `current_mode`, `first_toggle_signal` and `counter_time` into the stand-mode event module and the fan/light datapaths.

---
 rtl/hood_mode_controller_pkg.sv | 31 +++
 rtl/hood_mode_controller_sec_tick_gen.sv | 30 +++
 rtl/hood_mode_controller.sv | 133 +++++++++++++
 tb/tb_hood_mode_controller.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/hood_mode_controller_pkg.sv
// Shared mode codes, widths and small helpers for the exhaust-hood mode sequencer.
package hood_mode_controller_pkg;

  localparam int MODE_WIDTH   = 3;
  // 18 bits covers 216000 (60 h in seconds) without wrap.
  localparam int MAX_WIDTH    = 18;
  localparam int COUNTER_1SEC = 100_000_000;

  typedef enum logic [MODE_WIDTH-1:0] {
    OFF_MODE    = 3'd0,
    STAND_MODE  = 3'd1,
    LEVEL1_MODE = 3'd2,
    LEVEL2_MODE = 3'd3,
    LEVEL3_MODE = 3'd4,
    CLEAN_MODE  = 3'd5
  } mode_e;

  typedef struct packed {
    logic  valid;
    mode_e target;
  } mode_req_t;

  function automatic mode_req_t go(input mode_e target);
    return '{valid: 1'b1, target: target};
  endfunction

  function automatic logic is_timed(input mode_e m);
    return (m == STAND_MODE) || (m == LEVEL3_MODE) || (m == CLEAN_MODE);
  endfunction

endpackage

// File: rtl/hood_mode_controller_sec_tick_gen.sv
// One-second tick generator: counts 0..CLK_PER_SEC-1, tick is high at terminal count.
module sec_tick_gen #(
  parameter int CLK_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);

  localparam int            CW       = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLK_PER_SEC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERMINAL);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is asynchronous, active-low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hood_mode_controller.sv
// Hood mode sequencer: turns key pulses into current_mode and enforces the
// STAND auto-off, LEVEL3 boost cap and self-clean durations.
module hood_mode_controller
  import hood_mode_controller_pkg::*;
#(
  parameter int CLK_PER_SEC  = COUNTER_1SEC,
  parameter int AUTO_OFF_SEC = 300,
  parameter int L3_SEC       = 60,
  parameter int CLEAN_SEC    = 180
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  btn_power,
  input  logic                  btn_l1,
  input  logic                  btn_l2,
  input  logic                  btn_l3,
  input  logic                  btn_clean,
  output logic [MODE_WIDTH-1:0] current_mode,
  output logic                  first_toggle_signal,
  output logic [MAX_WIDTH-1:0]  counter_time,
  output logic [MAX_WIDTH-1:0]  remaining_sec,
  output logic                  l3_used
);

  localparam logic [MAX_WIDTH-1:0] AUTO_OFF_V = MAX_WIDTH'(AUTO_OFF_SEC);
  localparam logic [MAX_WIDTH-1:0] L3_V       = MAX_WIDTH'(L3_SEC);
  localparam logic [MAX_WIDTH-1:0] CLEAN_V    = MAX_WIDTH'(CLEAN_SEC);
  localparam logic [MAX_WIDTH-1:0] ONE_V      = MAX_WIDTH'(1);

  mode_e                mode_q;
  logic                 first_toggle_q;
  logic [MAX_WIDTH-1:0] counter_time_q;
  logic [MAX_WIDTH-1:0] remaining_q;
  logic                 l3_used_q;

  mode_req_t key_req;
  mode_req_t next_req;
  mode_e     timeout_target;
  logic      tick;
  logic      timeout;
  logic      l3_ok;

  assign l3_ok = btn_l3 && !l3_used_q;

  // Per-state key acceptance; the first accepted key in priority order wins.
  always_comb begin
    key_req = '{valid: 1'b0, target: mode_q};
    case (mode_q)
      OFF_MODE: begin
        if (btn_power) key_req = go(STAND_MODE);
      end
      STAND_MODE: begin
        if      (btn_power) key_req = go(OFF_MODE);
        else if (btn_clean) key_req = go(CLEAN_MODE);
        else if (l3_ok)     key_req = go(LEVEL3_MODE);
        else if (btn_l2)    key_req = go(LEVEL2_MODE);
        else if (btn_l1)    key_req = go(LEVEL1_MODE);
      end
      LEVEL1_MODE, LEVEL2_MODE, LEVEL3_MODE: begin
        if      (btn_power)                          key_req = go(STAND_MODE);
        else if (l3_ok)                              key_req = go(LEVEL3_MODE);
        else if (btn_l2 && mode_q != LEVEL2_MODE)    key_req = go(LEVEL2_MODE);
        else if (btn_l1 && mode_q != LEVEL1_MODE)    key_req = go(LEVEL1_MODE);
      end
      CLEAN_MODE: begin
        if (btn_power) key_req = go(OFF_MODE);
      end
      default: key_req = go(OFF_MODE);
    endcase
  end

  always_comb begin
    timeout_target = OFF_MODE;
    if (mode_q == LEVEL3_MODE) timeout_target = LEVEL2_MODE;
  end

  // The last second expires into the timeout transition instead of reaching 0.
  assign timeout  = tick && is_timed(mode_q) && (remaining_q == ONE_V);
  // A key on a tick cycle takes precedence over the tick.
  assign next_req = key_req.valid ? key_req
                  : (timeout ? go(timeout_target) : '{valid: 1'b0, target: mode_q});

  sec_tick_gen #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_sec_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .clear(next_req.valid),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q         <= OFF_MODE;
      first_toggle_q <= 1'b0;
      counter_time_q <= '0;
      remaining_q    <= '0;
      l3_used_q      <= 1'b0;
    end else begin
      first_toggle_q <= 1'b0;
      if (next_req.valid) begin
        mode_q <= next_req.target;
        case (next_req.target)
          OFF_MODE: begin
            remaining_q    <= '0;
            counter_time_q <= '0;
            l3_used_q      <= 1'b0;
          end
          STAND_MODE: begin
            remaining_q    <= AUTO_OFF_V;
            counter_time_q <= AUTO_OFF_V;
            first_toggle_q <= 1'b1;
          end
          LEVEL3_MODE: begin
            remaining_q <= L3_V;
            l3_used_q   <= 1'b1;
          end
          CLEAN_MODE: remaining_q <= CLEAN_V;
          default:    remaining_q <= '0;
        endcase
      end else if (tick && is_timed(mode_q)) begin
        remaining_q <= remaining_q - ONE_V;
      end
    end
  end

  assign current_mode        = mode_q;
  assign first_toggle_signal = first_toggle_q;
  assign counter_time        = counter_time_q;
  assign remaining_sec       = remaining_q;
  assign l3_used             = l3_used_q;

endmodule

// File: tb/tb_hood_mode_controller.sv
// Directed bench for hood_mode_controller with shortened timing parameters.
module tb_hood_mode_controller;

  localparam int MW = 3;
  localparam int XW = 18;

  // Expected mode codes, written out independently of the design package.
  localparam int M_OFF = 0, M_STAND = 1, M_L1 = 2, M_L2 = 3, M_L3 = 4, M_CLEAN = 5;

  // Key vector order: {power, clean, l3, l2, l1}
  localparam logic [4:0] K_PWR = 5'b10000, K_CLN = 5'b01000, K_L3 = 5'b00100,
                         K_L2  = 5'b00010, K_L1  = 5'b00001;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          btn_power = 1'b0, btn_l1 = 1'b0, btn_l2 = 1'b0, btn_l3 = 1'b0, btn_clean = 1'b0;
  logic [MW-1:0] current_mode;
  logic          first_toggle_signal;
  logic [XW-1:0] counter_time;
  logic [XW-1:0] remaining_sec;
  logic          l3_used;

  int n_checks = 0;
  int n_errors = 0;

  hood_mode_controller #(
    .CLK_PER_SEC (4),
    .AUTO_OFF_SEC(5),
    .L3_SEC      (3),
    .CLEAN_SEC   (4)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .btn_power          (btn_power),
    .btn_l1             (btn_l1),
    .btn_l2             (btn_l2),
    .btn_l3             (btn_l3),
    .btn_clean          (btn_clean),
    .current_mode       (current_mode),
    .first_toggle_signal(first_toggle_signal),
    .counter_time       (counter_time),
    .remaining_sec      (remaining_sec),
    .l3_used            (l3_used)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int mode, input int rem, input int ct,
                           input int l3u, input int ft);
    check({tag, ".mode"}, 32'(current_mode), 32'(mode));
    check({tag, ".rem"},  32'(remaining_sec), 32'(rem));
    check({tag, ".ct"},   32'(counter_time), 32'(ct));
    check({tag, ".l3u"},  32'(l3_used), 32'(l3u));
    check({tag, ".ft"},   32'(first_toggle_signal), 32'(ft));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle key pulse; returns at the negedge after the sampling edge.
  task automatic press(input logic [4:0] k);
    {btn_power, btn_clean, btn_l3, btn_l2, btn_l1} = k;
    @(negedge clk);
    {btn_power, btn_clean, btn_l3, btn_l2, btn_l1} = 5'b0;
  endtask

  initial begin
    // Reset state
    wait_cycles(2);
    check_all("rst", M_OFF, 0, 0, 0, 0);
    rstn = 1'b1;
    wait_cycles(1);
    press(K_L1 | K_L3 | K_CLN);
    check_all("off_ignore", M_OFF, 0, 0, 0, 0);

    // 1: STAND entry and idle auto-off after 20 cycles
    press(K_PWR);
    check_all("s1_entry", M_STAND, 5, 5, 0, 1);
    wait_cycles(1);
    check("s1_ft_once", 32'(first_toggle_signal), 32'd0);
    wait_cycles(2);
    check("s1_rem_c3", 32'(remaining_sec), 32'd5);
    wait_cycles(1);
    check("s1_rem_c4", 32'(remaining_sec), 32'd4);
    wait_cycles(15);
    check_all("s1_c19", M_STAND, 1, 5, 0, 0);
    wait_cycles(1);
    check_all("s1_off", M_OFF, 0, 0, 0, 0);

    // 2: boost cap and l3 reuse lockout
    press(K_PWR);
    press(K_L3);
    check_all("s2_l3", M_L3, 3, 5, 1, 0);
    wait_cycles(11);
    check_all("s2_c11", M_L3, 1, 5, 1, 0);
    wait_cycles(1);
    check_all("s2_l2", M_L2, 0, 5, 1, 0);
    press(K_L3);
    check_all("s2_l3_ign", M_L2, 0, 5, 1, 0);

    // 3: back to STAND; ignored l3 must not disturb the countdown
    press(K_PWR);
    check_all("s3_stand", M_STAND, 5, 5, 1, 1);
    wait_cycles(2);
    press(K_L3);
    check_all("s3_l3_ign", M_STAND, 5, 5, 1, 0);
    wait_cycles(1);
    check("s3_rem_c4", 32'(remaining_sec), 32'd4);

    // 4: self-clean timeout to OFF clears l3_used
    press(K_CLN);
    check_all("s4_clean", M_CLEAN, 4, 5, 1, 0);
    wait_cycles(5);
    press(K_L1);
    check_all("s4_l1_ign", M_CLEAN, 3, 5, 1, 0);
    wait_cycles(9);
    check_all("s4_c15", M_CLEAN, 1, 5, 1, 0);
    wait_cycles(1);
    check_all("s4_off", M_OFF, 0, 0, 0, 0);

    // 5: key priority and key-over-tick
    press(K_PWR);
    press(K_PWR | K_L2);
    check_all("s5_pwr_l2", M_OFF, 0, 0, 0, 0);
    press(K_PWR);
    press(K_L1);
    check_all("s5_l1", M_L1, 0, 5, 0, 0);
    press(K_L2 | K_L1);
    check_all("s5_l2_l1", M_L2, 0, 5, 0, 0);
    press(K_PWR);
    check_all("s5_stand", M_STAND, 5, 5, 0, 1);
    wait_cycles(3);
    press(K_L1);
    check_all("s5_tick_key", M_L1, 0, 5, 0, 0);

    // 6: asynchronous reset in LEVEL3
    press(K_L3);
    check_all("s6_l3", M_L3, 3, 5, 1, 0);
    wait_cycles(2);
    rstn = 1'b0;
    #1;
    check_all("s6_rst", M_OFF, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    press(K_PWR);
    check_all("s6_stand", M_STAND, 5, 5, 0, 1);
    press(K_L3);
    check_all("s6_l3_again", M_L3, 3, 5, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
